// File: rtl/fu_issue_scheduler.sv
// Oldest-first issue scheduler: picks the ready RS entry closest to the ROB head
// and holds the issued op in a one-entry output register toward the functional unit.
module fu_issue_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 4,
  parameter int PAYLOAD_W = 64,
  localparam int SRC_W    = $clog2(NUM_REQ)
) (
  input  logic                           in_clk,
  input  logic                           in_rst,
  input  logic [NUM_REQ-1:0]             in_req_valid,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   in_req_rob_idx,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   in_req_payload,
  input  logic [ROB_IDX_W-1:0]           in_rob_head,
  input  logic                           in_flush,
  input  logic                           in_fu_ready,
  output logic [NUM_REQ-1:0]             out_req_grant,
  output logic                           out_fu_valid,
  output logic [ROB_IDX_W-1:0]           out_fu_rob_idx,
  output logic [PAYLOAD_W-1:0]           out_fu_payload,
  output logic [SRC_W-1:0]               out_fu_src,
  output logic [31:0]                    out_issue_count
);

  // Handshakes: RS side, out_req_grant[i] is the same-cycle accept of in_req_valid[i]
  // (entry deallocates at that edge); FU side, an op transfers on any edge where
  // out_fu_valid && in_fu_ready, and the held op never changes while it is waiting.

  logic                 any_valid;
  logic [SRC_W-1:0]     win_idx;
  logic [ROB_IDX_W-1:0] win_rob;
  logic [PAYLOAD_W-1:0] win_payload;
  logic [ROB_IDX_W-1:0] best_age;
  logic [ROB_IDX_W-1:0] age;
  logic                 can_accept;
  logic                 issue;
  logic                 drain;

  // Age is the modular distance from the head, so wrap-around needs no special case.
  // Strict less-than keeps the lowest index on a duplicate-age tie.
  always_comb begin
    any_valid   = 1'b0;
    win_idx     = '0;
    win_rob     = '0;
    win_payload = '0;
    best_age    = '0;
    age         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      age = in_req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W] - in_rob_head;
      if (in_req_valid[i] && (!any_valid || (age < best_age))) begin
        any_valid   = 1'b1;
        best_age    = age;
        win_idx     = SRC_W'(i);
        win_rob     = in_req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
        win_payload = in_req_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  assign can_accept = !out_fu_valid || in_fu_ready;
  assign issue      = any_valid && can_accept && !in_flush && in_rst;
  assign drain      = out_fu_valid && in_fu_ready;

  always_comb begin
    out_req_grant = '0;
    if (issue) out_req_grant[win_idx] = 1'b1;
  end

  // A flush drops the held op without counting it; the data fields stay stale.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      out_fu_valid    <= 1'b0;
      out_fu_rob_idx  <= '0;
      out_fu_payload  <= '0;
      out_fu_src      <= '0;
      out_issue_count <= '0;
    end else if (in_flush) begin
      out_fu_valid <= 1'b0;
    end else begin
      if (drain) out_issue_count <= out_issue_count + 32'd1;
      if (issue) begin
        out_fu_valid   <= 1'b1;
        out_fu_rob_idx <= win_rob;
        out_fu_payload <= win_payload;
        out_fu_src     <= win_idx;
      end else if (drain) begin
        out_fu_valid <= 1'b0;
      end
    end
  end

endmodule
